// File: rtl/mac_vlg_tx.sv
// Ethernet MAC transmit path: preamble/SFD, 14-byte header, payload, optional pad, FCS, IFG.
// Optional zero-padding of short payloads is compiled in with `define MAC_VLG_TX_PAD_EN.
//   state | meaning
//   IDLE  | wait for val_i, latch header, emit first preamble byte
//   PRE   | remaining six 0x55 bytes
//   SFD   | 0xD5
//   HDR   | dst, src, etyp, MSB byte first
//   PAY   | rdy_o high, stream payload; val_i low aborts
//   PAD   | 0x00 fill up to MIN_PAYLOAD
//   FCS   | complemented CRC, LSB byte first
//   IFG   | IFG_BYTES idle cycles
module mac_vlg_tx #(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 46
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [47:0] hdr_dst_i,
    input  logic [47:0] hdr_src_i,
    input  logic [15:0] hdr_etyp_i,
    input  logic [7:0]  dat_i,
    input  logic        val_i,
    input  logic        last_i,
    output logic        rdy_o,
    output logic [7:0]  phy_dat_o,
    output logic        phy_val_o,
    output logic        phy_err_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        underrun_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [15:0] IFG_LOAD = 16'(IFG_BYTES - 1);

    state_t       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [10:0]  pay_cnt_q, pay_cnt_d, pay_cnt_inc;
    logic [111:0] hdr_q, hdr_d;
    logic [31:0]  crc_q, crc_d;
    logic [7:0]   phy_dat_q, phy_dat_d;
    logic         phy_val_q, phy_val_d;
    logic         phy_err_q, phy_err_d;
    logic         done_q, done_d;
    logic         underrun_q, underrun_d;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign pay_cnt_inc = (pay_cnt_q == 11'h7FF) ? pay_cnt_q : pay_cnt_q + 11'd1;

`ifdef MAC_VLG_TX_PAD_EN
    localparam logic [10:0] MIN_C = 11'(MIN_PAYLOAD);
    logic pay_short;
    // count includes the byte being sent this cycle
    assign pay_short = (pay_cnt_inc < MIN_C);
`else
    logic unused_min;
    assign unused_min = (MIN_PAYLOAD > 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pay_cnt_q  <= '0;
            hdr_q      <= '0;
            crc_q      <= 32'hFFFFFFFF;
            phy_dat_q  <= 8'h00;
            phy_val_q  <= 1'b0;
            phy_err_q  <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            hdr_q      <= hdr_d;
            crc_q      <= crc_d;
            phy_dat_q  <= phy_dat_d;
            phy_val_q  <= phy_val_d;
            phy_err_q  <= phy_err_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (val_i) state_d = S_PRE;
            S_PRE:  if (cnt_q == 16'd0) state_d = S_SFD;
            S_SFD:  state_d = S_HDR;
            S_HDR:  if (cnt_q == 16'd0) state_d = S_PAY;
            S_PAY: begin
                if (!val_i) begin
                    state_d = S_IFG;
                end else if (last_i) begin
`ifdef MAC_VLG_TX_PAD_EN
                    state_d = pay_short ? S_PAD : S_FCS;
`else
                    state_d = S_FCS;
`endif
                end
            end
`ifdef MAC_VLG_TX_PAD_EN
            S_PAD:  if (!pay_short) state_d = S_FCS;
`endif
            S_FCS:  if (cnt_q == 16'd0) state_d = S_IFG;
            S_IFG:  if (cnt_q == 16'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and next registered outputs: each byte is driven the cycle after its state.
    always_comb begin
        cnt_d      = cnt_q;
        pay_cnt_d  = pay_cnt_q;
        hdr_d      = hdr_q;
        crc_d      = crc_q;
        phy_dat_d  = 8'h00;
        phy_val_d  = 1'b0;
        phy_err_d  = 1'b0;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (val_i) begin
                    cnt_d     = 16'd5;
                    pay_cnt_d = '0;
                    hdr_d     = {hdr_dst_i, hdr_src_i, hdr_etyp_i};
                    crc_d     = 32'hFFFFFFFF;
                    phy_dat_d = 8'h55;
                    phy_val_d = 1'b1;
                end
            end
            S_PRE: begin
                cnt_d     = cnt_q - 16'd1;
                phy_dat_d = 8'h55;
                phy_val_d = 1'b1;
            end
            S_SFD: begin
                cnt_d     = 16'd13;
                phy_dat_d = 8'hD5;
                phy_val_d = 1'b1;
            end
            S_HDR: begin
                cnt_d     = cnt_q - 16'd1;
                phy_dat_d = hdr_q[111:104];
                phy_val_d = 1'b1;
                crc_d     = crc_upd(crc_q, hdr_q[111:104]);
                hdr_d     = {hdr_q[103:0], 8'h00};
            end
            S_PAY: begin
                phy_val_d = 1'b1;
                if (val_i) begin
                    cnt_d     = 16'd3;
                    phy_dat_d = dat_i;
                    crc_d     = crc_upd(crc_q, dat_i);
                    pay_cnt_d = pay_cnt_inc;
                end else begin
                    cnt_d      = IFG_LOAD;
                    phy_err_d  = 1'b1;
                    underrun_d = 1'b1;
                end
            end
`ifdef MAC_VLG_TX_PAD_EN
            S_PAD: begin
                cnt_d     = 16'd3;
                phy_val_d = 1'b1;
                crc_d     = crc_upd(crc_q, 8'h00);
                pay_cnt_d = pay_cnt_inc;
            end
`endif
            S_FCS: begin
                phy_dat_d = ~crc_q[7:0];
                phy_val_d = 1'b1;
                crc_d     = {8'h00, crc_q[31:8]};
                if (cnt_q == 16'd0) begin
                    cnt_d  = IFG_LOAD;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_IFG: begin
                cnt_d = cnt_q - 16'd1;
            end
            default: ;
        endcase
    end

    assign rdy_o      = (state_q == S_PAY);
    assign busy_o     = (state_q != S_IDLE);
    assign phy_dat_o  = phy_dat_q;
    assign phy_val_o  = phy_val_q;
    assign phy_err_o  = phy_err_q;
    assign done_o     = done_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_mac_vlg_tx.sv
// Self-checking bench for mac_vlg_tx: random frames against a byte-level frame model.
module tb_mac_vlg_tx;

    localparam int IFG = 12;
    localparam int MIN = 46;
`ifdef MAC_VLG_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] hdr_dst, hdr_src;
    logic [15:0] hdr_etyp;
    logic [7:0]  dat;
    logic        val, last;
    logic        rdy, phy_val, phy_err, busy, done, underrun;
    logic [7:0]  phy_dat;

    logic [47:0] f_dst, f_src;
    logic [15:0] f_etyp;

    int checks = 0;
    int errors = 0;

    mac_vlg_tx #(.IFG_BYTES(IFG), .MIN_PAYLOAD(MIN)) dut (
        .clk_i(clk), .rst_i(rst),
        .hdr_dst_i(hdr_dst), .hdr_src_i(hdr_src), .hdr_etyp_i(hdr_etyp),
        .dat_i(dat), .val_i(val), .last_i(last), .rdy_o(rdy),
        .phy_dat_o(phy_dat), .phy_val_o(phy_val), .phy_err_o(phy_err),
        .busy_o(busy), .done_o(done), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ethernet CRC-32, one bit at a time, LSB of each byte first
    function automatic logic [31:0] crc_model(input bq_t b);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_hdr();
        f_dst  = {$urandom_range(0, 65535), $urandom};
        f_src  = {$urandom_range(0, 65535), $urandom};
        f_etyp = 16'($urandom_range(0, 65535));
    endtask

    // n payload bytes; ur_at >= 0 drops val when that byte is due; keep_val holds the
    // request high after the frame; pre_started means the first 0x55 is already on the wire.
    task automatic do_frame(input string tag, input int n, input int ur_at, input bit ab,
                            input bit keep_val, input bit pre_started);
        bq_t pay, body, exp, got;
        logic [31:0] fcs;
        int idx, cyc, n_done, n_ur, n_err, gaps, first_rdy, hv, len_exp;
        bit prev_xfer, ended;
        pay = {}; body = {}; exp = {}; got = {};
        for (int i = 0; i < n; i++) pay.push_back(ab ? 8'hAB : 8'($urandom_range(0, 255)));
        for (int i = 0; i < 6; i++) body.push_back(f_dst[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) body.push_back(f_src[8*(5-i) +: 8]);
        body.push_back(f_etyp[15:8]);
        body.push_back(f_etyp[7:0]);
        if (ur_at < 0) begin
            foreach (pay[i]) body.push_back(pay[i]);
            while (PAD_ON && body.size() < 14 + MIN) body.push_back(8'h00);
            fcs = ~crc_model(body);
            for (int i = 0; i < 4; i++) body.push_back(fcs[8*i +: 8]);
        end else begin
            for (int i = 0; i < ur_at; i++) body.push_back(pay[i]);
            body.push_back(8'h00);
        end
        for (int i = 0; i < 7; i++) exp.push_back(8'h55);
        exp.push_back(8'hD5);
        foreach (body[i]) exp.push_back(body[i]);

        if (pre_started) begin
            cyc = 1;
            got.push_back(phy_dat);
        end else begin
            cyc = 0;
            hdr_dst = f_dst; hdr_src = f_src; hdr_etyp = f_etyp;
            val = 1'b1; dat = 8'($urandom); last = 1'b0;
        end
        idx = 0; n_done = 0; n_ur = 0; n_err = 0; gaps = 0; first_rdy = -1;
        prev_xfer = 1'b0; ended = 1'b0;
        while (!ended && cyc < 4000) begin
            step();
            cyc++;
            if (prev_xfer) idx++;
            hdr_dst = {$urandom_range(0, 65535), $urandom};
            hdr_src = {$urandom_range(0, 65535), $urandom};
            hdr_etyp = 16'($urandom_range(0, 65535));
            if (phy_val) got.push_back(phy_dat);
            else if (got.size() > 0) gaps++;
            if (phy_err) n_err++;
            if (done) n_done++;
            if (underrun) n_ur++;
            if (done || underrun) ended = 1'b1;
            if (rdy && first_rdy < 0) first_rdy = cyc;
            prev_xfer = 1'b0;
            if (rdy && idx == ur_at) begin
                val = 1'b0; last = 1'($urandom_range(0, 1));
            end else if (rdy && idx < n) begin
                val = 1'b1; dat = pay[idx]; last = (idx == n - 1); prev_xfer = 1'b1;
            end else begin
                val = (ended || idx >= n) ? keep_val : 1'b1;
                dat = 8'($urandom); last = 1'($urandom_range(0, 1));
            end
        end
        chk({tag, " end_seen"}, 32'(ended), 32'd1);
        chk({tag, " first_rdy_cycle"}, 32'(first_rdy), 32'd22);
        chk({tag, " wire_len"}, 32'(got.size()), 32'(exp.size()));
        if (ur_at < 0) begin
            len_exp = 8 + 14 + ((PAD_ON && n < MIN) ? MIN : n) + 4;
            chk({tag, " frame_len"}, 32'(got.size()), 32'(len_exp));
            if (got.size() > 8)
                chk({tag, " crc_residue"}, bitrev(crc_model(got[8:$])), 32'hC704DD7B);
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        chk({tag, " phy_val_gaps"}, 32'(gaps), 32'd0);
        chk({tag, " done_pulses"}, 32'(n_done), (ur_at < 0) ? 32'd1 : 32'd0);
        chk({tag, " underrun_pulses"}, 32'(n_ur), (ur_at < 0) ? 32'd0 : 32'd1);
        chk({tag, " err_cycles"}, 32'(n_err), (ur_at < 0) ? 32'd0 : 32'd1);

        if (keep_val) rand_hdr();
        hdr_dst = f_dst; hdr_src = f_src; hdr_etyp = f_etyp;
        val = keep_val;
        hv = 0;
        for (int k = 0; k < IFG; k++) begin
            step();
            if (phy_val || done || underrun) hv++;
        end
        chk({tag, " ifg_quiet"}, 32'(hv), 32'd0);
        chk({tag, " idle_after_ifg"}, 32'(busy), 32'd0);
        if (keep_val) begin
            step();
            chk({tag, " b2b_pre_val"}, 32'(phy_val), 32'd1);
            chk({tag, " b2b_pre_dat"}, 32'(phy_dat), 32'h55);
        end
    endtask

    initial begin
        int nb, budget;
        rst = 1'b1; val = 1'b0; last = 1'b0; dat = 8'h00;
        hdr_dst = '0; hdr_src = '0; hdr_etyp = '0;
        repeat (3) step();
        chk("rst phy_dat", 32'(phy_dat), 32'h00);
        chk("rst phy_val", 32'(phy_val), 32'd0);
        chk("rst phy_err", 32'(phy_err), 32'd0);
        chk("rst rdy", 32'(rdy), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        f_dst = 48'hFFFFFFFFFFFF; f_src = {$urandom_range(0, 65535), $urandom}; f_etyp = 16'h0806;
        do_frame("bcast46", 46, -1, 1'b0, 1'b0, 1'b0);

        rand_hdr();
        do_frame("one_ab", 1, -1, 1'b1, 1'b0, 1'b0);

        rand_hdr();
        do_frame("b2b_a", 20, -1, 1'b0, 1'b1, 1'b0);
        do_frame("b2b_b", 30, -1, 1'b0, 1'b0, 1'b1);

        rand_hdr();
        do_frame("underrun", 100, 10, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            rand_hdr();
            do_frame($sformatf("rnd%0d", r), int'($urandom_range(1, 80)), -1, 1'b0, 1'b0, 1'b0);
        end

        // reset while header bytes are on the wire
        rand_hdr();
        hdr_dst = f_dst; hdr_src = f_src; hdr_etyp = f_etyp;
        val = 1'b1; nb = 0; budget = 0;
        while (nb < 13 && budget < 40) begin
            step();
            budget++;
            if (phy_val) nb++;
        end
        chk("midrst reached_hdr", 32'(nb), 32'd13);
        rst = 1'b1;
        step();
        rst = 1'b0; val = 1'b0;
        chk("midrst phy_val", 32'(phy_val), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst rdy", 32'(rdy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        repeat (3) step();
        rand_hdr();
        do_frame("after_rst", 50, -1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_vlg_tx.md
# mac_vlg_tx

Ethernet MAC transmit path: turns a user frame (header fields plus a byte stream payload) into a GMII-style 8-bit PHY stream. It generates preamble and SFD, serialises the 14-byte MAC header, streams the payload, pads short frames, appends the FCS, and enforces the inter-packet gap. It sits between the upper-layer packet muxes and the PHY, as the counterpart of `mac_vlg_rx`, and shares its PHY byte conventions.

## Interface

- `IFG_BYTES`, default 12: idle cycles enforced after the last FCS byte.
- `MIN_PAYLOAD`, default 46: minimum payload length after padding.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hdr_dst` in 48: destination MAC; MSB byte goes on the wire first.
- `hdr_src` in 48: source MAC.
- `hdr_etyp` in 16: EtherType.
- `dat` in 8: payload byte.
- `val` in 1: payload byte valid; also the frame request while in IDLE.
- `last` in 1: marks the final payload byte, qualified by `val && rdy`.
- `rdy` out 1: MAC accepts a payload byte this cycle.
- `phy_dat` out 8: byte to PHY.
- `phy_val` out 1: PHY byte valid.
- `phy_err` out 1: PHY error indication.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a frame completes normally.
- `underrun` out 1: one-cycle pulse when a frame is aborted.

## Operation

- States and sequence: IDLE → PRE (7 × 0x55) → SFD (0xD5) → HDR (14 bytes: dst, src, etyp, big-endian) → PAY → PAD (optional) → FCS (4 bytes) → IFG → IDLE.
- IDLE → PRE when `val`=1.
  - `hdr_*` are latched on that cycle and ignored afterwards.
  - The first payload byte is not consumed here.
- `rdy` is combinational and equals (state==PAY). A byte transfers when `val && rdy`.
- In PAY:
  - Each transferred byte is emitted on `phy_dat` the next cycle.
  - A transfer with `last`=1 ends PAY. The next state is PAD if the payload count is below `MIN_PAYLOAD` (PAD feature compiled in), otherwise FCS.
- Underrun: `val`=0 while in PAY aborts the frame.
  - The next cycle drives `phy_val`=1, `phy_err`=1, `phy_dat`=0x00.
  - `underrun` pulses on that same cycle.
  - The block then goes to IFG. No FCS is sent and `done` does not pulse.
- PAD emits 0x00 bytes until the payload count equals `MIN_PAYLOAD`.
- Payload counter:
  - 11 bits, saturating at 2047.
  - Cleared on IDLE→PRE.
  - Incremented per payload or pad byte.
  - No maximum length is enforced.
- CRC32:
  - Reflected polynomial 0x04C11DB7, initialised to 0xFFFFFFFF on entry to PRE.
  - Updated per byte over HDR, PAY and PAD bytes only.
  - The FCS is the complemented register, sent LSB byte first.
- IFG runs for `IFG_BYTES` cycles with `phy_val`=0, then returns to IDLE.
  - A `val` already high is taken on the IDLE cycle that follows.
- `done` pulses on the cycle the final FCS byte is on `phy_dat`.

## Timing

- Reset values:
  - State is IDLE.
  - `phy_dat`=0x00, `phy_val`=0, `phy_err`=0.
  - `rdy`=0, `busy`=0, `done`=0, `underrun`=0.
  - Counters are 0 and the CRC register is 0xFFFFFFFF.
- All PHY outputs are registered.
  - `val` rising in IDLE at cycle 0 gives the first 0x55 on `phy_dat` at cycle 1.
  - The SFD appears at cycle 8 and the first header byte at cycle 9.
- `rdy` first asserts at cycle 22 (the cycle after the last HDR byte is registered out); a byte accepted at cycle N is driven at N+1.
- `phy_val` is continuously high from the first preamble byte to the last FCS byte. The only gap is an underrun.
- Frame on wire is 8 + 14 + max(payload, `MIN_PAYLOAD`) + 4 cycles.
- Back-to-back frames: the next preamble starts `IFG_BYTES`+1 cycles after the last FCS byte (the IFG cycles plus one IDLE cycle).
- Reset mid-frame: all outputs take their reset values the cycle after `rst` is sampled high. The partial frame is not completed or flagged.
- `last` with `val`=0 is ignored. `val`/`last` outside PAY are ignored, except `val` in IDLE.

## Configuration

- `MAC_VLG_TX_PAD_EN` defined:
  - The PAD state is compiled in.
  - Short payloads are zero-padded to `MIN_PAYLOAD`, so the minimum wire frame is 72 bytes including preamble.
- Not defined:
  - PAD is removed and PAY goes directly to FCS.
  - Short frames are sent as-is; padding is the upper layer's responsibility.
  - `MIN_PAYLOAD` is unused.

## Test plan

- 46-byte payload, dst FF:FF:FF:FF:FF:FF, etyp 0x0806 → 72 contiguous `phy_val` cycles: 7×0x55, 0xD5, header bytes in order, payload, 4 FCS bytes. The CRC over header+payload+FCS leaves residue 0xC704DD7B. `done` pulses once.
- 1-byte payload 0xAB with PAD_EN → 45 × 0x00 pad bytes, 72 wire bytes, correct FCS. Without PAD_EN → 27 wire bytes.
- Two frames with `val` held high → the second preamble byte appears exactly 13 cycles after the first frame's last FCS byte. No `phy_val` during the 12 IFG cycles.
- `val` dropped at payload byte 10 of 100 → one cycle with `phy_err`=1, `phy_dat`=0x00, `underrun`=1; no FCS; `done` stays 0; IFG is then honoured.
- `rst` asserted during HDR byte 5 → the next cycle has `phy_val`=0, `busy`=0, `rdy`=0. A new frame requested afterwards starts with a clean preamble and a fresh CRC.
- Header fields changed while `busy` → wire header matches the values latched at request time.
